stream_upsize: RTL and testbench
================================

STREAM_UPSIZE -- requirements
Module: stream_upsize

Interface
REQ-001 The block SHALL have parameter T_DATA_WIDTH, default 8, giving the width of one input beat and of one output lane.
REQ-002 The block SHALL have parameter T_DATA_RATIO, default 4, giving the number of input beats packed into one output word; legal values are 2 or more.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-high reset (1 = reset asserted).
REQ-006 Port s_data_i, input, T_DATA_WIDTH bits: input beat data.
REQ-007 Port s_last_i, input, 1 bit: the input beat is the last beat of a packet.
REQ-008 Port s_valid_i, input, 1 bit: the input beat is valid.
REQ-009 Port s_ready_o, output, 1 bit: the block can accept an input beat.
REQ-010 Port m_data_o, output, unpacked array [T_DATA_RATIO-1:0] of T_DATA_WIDTH bits: output lanes; lane 0 holds the earliest beat.
REQ-011 Port m_keep_o, output, T_DATA_RATIO bits: bit i is 1 when lane i holds a valid beat.
REQ-012 Port m_last_o, output, 1 bit: the output word ends a packet.
REQ-013 Port m_valid_o, output, 1 bit: the output word is valid.
REQ-014 Port m_ready_i, input, 1 bit: the downstream sink accepts the output word.

Function
REQ-015 An input beat SHALL be accepted only on a rising edge where s_valid_i and s_ready_o are both 1.
REQ-016 s_ready_o SHALL be combinational and equal to (not m_valid_o) or m_ready_i.
REQ-017 Accepted beats SHALL be written into consecutive lanes of a collection buffer, starting at lane 0, with a lane counter ranging 0..T_DATA_RATIO-1.
REQ-018 Internal signal fifo_full SHALL be 1 when the counter equals T_DATA_RATIO-1, meaning the next accepted beat completes the word.
REQ-019 Accepting a beat while fifo_full=1 or s_last_i=1 SHALL load the output register on that same edge.
  - Data: the buffered lanes plus the current beat in the current lane.
  - m_keep_o: ones in lanes 0..counter, zeros above.
  - m_last_o: equal to s_last_i.
  - m_valid_o: 1 from the next cycle onward.
  - The counter and buffer clear on the same edge.
REQ-020 Lanes not filled in a partial word (s_last_i before the word is full) SHALL be output as 0, with the corresponding m_keep_o bits at 0.
REQ-021 Latency from acceptance of the completing beat to m_valid_o=1 SHALL be exactly 1 cycle; there is no added bubble between words.
REQ-022 m_valid_o, m_data_o, m_keep_o and m_last_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-023 On an edge with m_valid_o=1 and m_ready_i=1 and no new word loaded, m_valid_o SHALL clear to 0.
REQ-024 If a new word loads on the same edge as an output transfer, the new word SHALL replace the old one and m_valid_o SHALL stay 1.
REQ-025 A beat accepted while the counter is below T_DATA_RATIO-1 and s_last_i=0 SHALL only be buffered and SHALL NOT change the outputs.
REQ-026 When s_valid_i=0, state SHALL be unchanged apart from the output drain described in REQ-023.
REQ-027 The counter SHALL never exceed T_DATA_RATIO-1; it wraps to 0 on every word completion.

Reset
REQ-028 While rst_n=1, the following SHALL be cleared asynchronously to 0: the counter, the buffer, m_data_o, m_keep_o, m_last_o and m_valid_o.
REQ-029 In reset, s_ready_o SHALL evaluate to 1 (it is combinational and m_valid_o=0).
REQ-030 Reset asserted mid-packet SHALL discard any partially collected beats, and operation SHALL resume from lane 0.

Verification (T_DATA_WIDTH=4, T_DATA_RATIO=2, m_ready_i=1 unless stated)
REQ-031 Scenario "full word": beats 0x0 (last=0) then 0x1 (last=0) -> one cycle after the second beat, m_valid_o=1, m_data_o={lane0=0x0, lane1=0x1}, m_keep_o=2'b11, m_last_o=0.
REQ-032 Scenario "partial word": a single beat 0x2 with last=1 -> next cycle m_valid_o=1, lanes={0x2, 0x0}, m_keep_o=2'b01, m_last_o=1.
REQ-033 Scenario "idle gap": a cycle with s_valid_i=0, then 0xA (last=0), then 0xB (last=1) -> the idle cycle is ignored; output lanes={0xA, 0xB}, keep=2'b11, last=1; m_valid_o drops to 0 the cycle after.
REQ-034 Scenario "backpressure": m_ready_i=0 with a word pending -> s_ready_o=0, and m_data_o, m_keep_o, m_last_o and m_valid_o stay stable until m_ready_i=1.
REQ-035 Scenario "reset mid-word": accept 0x5 (last=0), assert rst_n -> all outputs 0; the next beats 0x6 then 0x7 produce lanes={0x6, 0x7}, with no 0x5 present.
REQ-036 Check at every edge: s_valid_i and (fifo_full or s_last_i) with acceptance SHALL give m_valid_o=1 after the edge, and m_last_o SHALL equal the accepted s_last_i.

Source files
------------

// File: rtl/stream_upsize.sv
// Packs T_DATA_RATIO narrow input beats into one wide output word.
// A packet may end early; unused lanes of that last word are zeroed and unkept.
module stream_upsize #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_DATA_RATIO = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0],
  output logic [T_DATA_RATIO-1:0] m_keep_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int CW = (T_DATA_RATIO > 1) ? $clog2(T_DATA_RATIO) : 1;
  localparam logic [CW-1:0] LastLane = CW'(T_DATA_RATIO - 1);

  logic [CW-1:0]           r_count;
  logic [T_DATA_WIDTH-1:0] r_buf [T_DATA_RATIO-1:0];

  logic                    w_accept;
  logic                    w_fifo_full;
  logic                    w_complete;
  logic [T_DATA_WIDTH-1:0] w_word [T_DATA_RATIO-1:0];
  logic [T_DATA_RATIO-1:0] w_keep;

  assign s_ready_o   = ~m_valid_o | m_ready_i;
  assign w_accept    = s_valid_i & s_ready_o;
  assign w_fifo_full = (r_count == LastLane);
  assign w_complete  = w_accept & (w_fifo_full | s_last_i);

  // Word to present: buffered lanes below the counter, the live beat at the
  // counter, and zeros above it so a short final word carries no stale data.
  always_comb begin
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      w_word[i] = '0;
      w_keep[i] = 1'b0;
      if (CW'(i) == r_count) begin
        w_word[i] = s_data_i;
        w_keep[i] = 1'b1;
      end else if (CW'(i) < r_count) begin
        w_word[i] = r_buf[i];
        w_keep[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_count   <= '0;
      m_keep_o  <= '0;
      m_last_o  <= 1'b0;
      m_valid_o <= 1'b0;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        r_buf[i]    <= '0;
        m_data_o[i] <= '0;
      end
    end else if (w_complete) begin
      r_count   <= '0;
      m_keep_o  <= w_keep;
      m_last_o  <= s_last_i;
      m_valid_o <= 1'b1;
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        r_buf[i]    <= '0;
        m_data_o[i] <= w_word[i];
      end
    end else begin
      if (w_accept) begin
        r_buf[r_count] <= s_data_i;
        r_count        <= r_count + CW'(1);
      end
      if (m_valid_o && m_ready_i) begin
        m_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_upsize.sv
// Directed bench for stream_upsize with 4-bit beats packed two to a word.
module tb_stream_upsize;

  logic       clk;
  logic       rst_n;
  logic [3:0] s_data_i;
  logic       s_last_i;
  logic       s_valid_i;
  logic       s_ready_o;
  logic [3:0] m_data_o [1:0];
  logic [1:0] m_keep_o;
  logic       m_last_o;
  logic       m_valid_o;
  logic       m_ready_i;

  int nChecks = 0;
  int nFails  = 0;

  stream_upsize #(.T_DATA_WIDTH(4), .T_DATA_RATIO(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data_i (s_data_i),
    .s_last_i (s_last_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_keep_o (m_keep_o),
    .m_last_o (m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one beat for one edge, then settle just past the edge and go idle.
  task automatic applyStimulus(input logic v, input logic [3:0] d, input logic l);
    s_valid_i = v;
    s_data_i  = d;
    s_last_i  = l;
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
  endtask

  task automatic checkWord(input string tag, input logic [7:0] data,
                           input logic [1:0] keep, input logic last);
    checkOutput({tag, ".valid"}, {31'd0, m_valid_o}, 32'd1);
    checkOutput({tag, ".data"}, {24'd0, m_data_o[1], m_data_o[0]}, {24'd0, data});
    checkOutput({tag, ".keep"}, {30'd0, m_keep_o}, {30'd0, keep});
    checkOutput({tag, ".last"}, {31'd0, m_last_o}, {31'd0, last});
  endtask

  // Lane model: any accepted beat that fills lane 1 or carries last must
  // produce a valid word right after that edge, with last copied over.
  int  tbLane = 0;
  logic expComplete;
  logic expLast;
  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tbLane = 0;
    end else begin
      expComplete = s_valid_i && s_ready_o && (tbLane == 1 || s_last_i);
      expLast     = s_last_i;
      if (s_valid_i && s_ready_o) tbLane = expComplete ? 0 : tbLane + 1;
      if (expComplete) begin
        #1;
        checkOutput("edgeValid", {31'd0, m_valid_o}, 32'd1);
        checkOutput("edgeLast", {31'd0, m_last_o}, {31'd0, expLast});
      end
    end
  end

  initial begin
    rst_n     = 1'b1;
    m_ready_i = 1'b1;
    s_valid_i = 1'b0;
    s_data_i  = '0;
    s_last_i  = 1'b0;
    #3;
    checkOutput("rstValid", {31'd0, m_valid_o}, 32'd0);
    checkOutput("rstData", {24'd0, m_data_o[1], m_data_o[0]}, 32'd0);
    checkOutput("rstKeep", {30'd0, m_keep_o}, 32'd0);
    checkOutput("rstLast", {31'd0, m_last_o}, 32'd0);
    checkOutput("rstReady", {31'd0, s_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    // Full word
    applyStimulus(1'b1, 4'h0, 1'b0);
    checkOutput("fullFirstBuffered", {31'd0, m_valid_o}, 32'd0);
    applyStimulus(1'b1, 4'h1, 1'b0);
    checkWord("full", 8'h10, 2'b11, 1'b0);

    // Partial word replaces the draining one without a bubble
    applyStimulus(1'b1, 4'h2, 1'b1);
    checkWord("partial", 8'h02, 2'b01, 1'b1);

    // Idle gap
    applyStimulus(1'b0, 4'hF, 1'b0);
    checkOutput("idleDrain", {31'd0, m_valid_o}, 32'd0);
    applyStimulus(1'b1, 4'hA, 1'b0);
    checkOutput("gapBuffered", {31'd0, m_valid_o}, 32'd0);
    applyStimulus(1'b1, 4'hB, 1'b1);
    checkWord("gap", 8'hBA, 2'b11, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("gapDrain", {31'd0, m_valid_o}, 32'd0);

    // Backpressure
    m_ready_i = 1'b0;
    applyStimulus(1'b1, 4'h3, 1'b0);
    applyStimulus(1'b1, 4'h4, 1'b1);
    checkWord("bpLoad", 8'h43, 2'b11, 1'b1);
    checkOutput("bpReady", {31'd0, s_ready_o}, 32'd0);
    applyStimulus(1'b1, 4'h5, 1'b1);
    checkWord("bpHold1", 8'h43, 2'b11, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkWord("bpHold2", 8'h43, 2'b11, 1'b1);
    m_ready_i = 1'b1;
    #1;
    checkOutput("bpReadyBack", {31'd0, s_ready_o}, 32'd1);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("bpDrain", {31'd0, m_valid_o}, 32'd0);

    // Reset mid-word discards the buffered beat
    applyStimulus(1'b1, 4'h5, 1'b0);
    checkOutput("midBuffered", {31'd0, m_valid_o}, 32'd0);
    rst_n = 1'b1;
    #2;
    checkOutput("midRstValid", {31'd0, m_valid_o}, 32'd0);
    checkOutput("midRstData", {24'd0, m_data_o[1], m_data_o[0]}, 32'd0);
    checkOutput("midRstReady", {31'd0, s_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    applyStimulus(1'b1, 4'h6, 1'b0);
    checkOutput("afterRstBuffered", {31'd0, m_valid_o}, 32'd0);
    applyStimulus(1'b1, 4'h7, 1'b0);
    checkWord("afterRst", 8'h76, 2'b11, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0);
    checkOutput("afterRstDrain", {31'd0, m_valid_o}, 32'd0);

    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
